// File: rtl/md_seq.sv
// Multi-cycle unsigned MULTU/DIVU sequencer driving a shared external 32-bit adder.
// 32 iterations of shift-add (multiply) or restoring shift-subtract (divide).
module md_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_ci,
    input  logic [31:0] add_s
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic OP_MULTU = 1'b0;

    state_t      r_state;
    state_t      w_next;
    logic        r_op;
    logic [4:0]  r_cnt;
    logic [31:0] r_d;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic        w_co;
    logic        w_take;
    logic [31:0] w_rem;

    assign w_accept = start && (r_state != S_RUN);
    assign w_rem    = {r_hi[30:0], r_lo[31]};
    // The adder has no carry-out; recover it from the operand and sum sign bits.
    assign w_co     = (add_a[31] & add_b[31]) | ((add_a[31] | add_b[31]) & ~add_s[31]);
    assign w_take   = r_hi[31] | w_co;

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign hi   = r_hi;
    assign lo   = r_lo;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        w_next = r_state;
        add_a  = 32'd0;
        add_b  = 32'd0;
        add_ci = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_RUN;
            end
            S_RUN: begin
                if (r_cnt == 5'd31) w_next = S_DONE;
                if (r_op == OP_MULTU) begin
                    add_a = r_hi;
                    add_b = r_lo[0] ? r_d : 32'd0;
                end else begin
                    add_a  = w_rem;
                    add_b  = ~r_d;
                    add_ci = 1'b1;
                end
            end
            S_DONE: begin
                w_next = start ? S_RUN : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op  <= 1'b0;
            r_cnt <= 5'd0;
            r_d   <= 32'd0;
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
        end else if (w_accept) begin
            r_op  <= op;
            r_d   <= b;
            r_hi  <= 32'd0;
            r_lo  <= a;
            r_cnt <= 5'd0;
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + 5'd1;
            if (r_op == OP_MULTU) begin
                if (r_lo[0]) begin
                    {r_hi, r_lo} <= {w_co, add_s, r_lo[31:1]};
                end else begin
                    {r_hi, r_lo} <= {1'b0, r_hi, r_lo[31:1]};
                end
            end else begin
                // Subtract succeeds when the 33-bit partial remainder is >= divisor.
                if (w_take) begin
                    r_hi <= add_s;
                    r_lo <= {r_lo[30:0], 1'b1};
                end else begin
                    r_hi <= w_rem;
                    r_lo <= {r_lo[30:0], 1'b0};
                end
            end
        end
    end

endmodule
